wb_cmd_master: RTL and testbench



---
 rtl/wb_cmd_master_pkg.sv | 14 +
 rtl/wb_cmd_wdog.sv | 27 ++
 rtl/wb_cmd_master.sv | 161 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared defaults and FSM state encoding for the Wishbone command master.
package wb_cmd_master_pkg;

    localparam int AW_DEF   = 8;
    localparam int LW_DEF   = 4;
    localparam int TO_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

endpackage

// File: rtl/wb_cmd_wdog.sv
// Bus-cycle watchdog: cleared on entry to a bus cycle, counts while enabled,
// flags expiry when the count reaches all-ones.
module wb_cmd_wdog #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = en && (cnt == '1);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone initiator driven by a valid/ready command stream, one response per beat.
// Optional bus timeout enabled by defining WB_CMD_TIMEOUT_EN.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
`ifdef WB_CMD_TIMEOUT_EN
    ,
    parameter int TO_W = TO_W_DEF
`endif
) (
    input  logic          clk,
    input  logic          rst,
    // Handshakes on cmd_* and rsp_*: a transfer happens on a rising clk edge
    // where valid and ready are both high; valid holds its payload until then.
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    input  logic [LW-1:0] cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_last,
    output logic [AW-1:0] wb_addr,
    output logic [31:0]   wb_wdata,
    output logic          wb_we,
    output logic          wb_cyc,
    input  logic [31:0]   wb_rdata,
    input  logic          wb_ack,
    output state_t        dbg_state
);

    state_t        state_q, state_d;
    logic [LW-1:0] beats_q;
    logic          more_beats;
    logic          expire;

    assign more_beats = (beats_q != '0);
    assign dbg_state  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_ack || expire) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = more_beats ? BUS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // cyc drops on the ack edge so a slave never sees cyc in the cycle after its ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cyc    <= 1'b0;
            wb_we     <= 1'b0;
            wb_addr   <= '0;
            wb_wdata  <= '0;
            beats_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_addr  <= cmd_addr;
                        wb_we    <= cmd_we;
                        wb_wdata <= cmd_wdata;
                        beats_q  <= cmd_len;
                        wb_cyc   <= 1'b1;
                    end
                end
                BUS: begin
                    if (wb_ack) begin
                        wb_cyc    <= 1'b0;
                        rsp_rdata <= wb_we ? 32'h0 : wb_rdata;
                        rsp_last  <= ~more_beats;
                        rsp_valid <= 1'b1;
                    end else if (expire) begin
                        // Timed-out beat ends the command; remaining beats are dropped.
                        wb_cyc    <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_last  <= 1'b1;
                        rsp_valid <= 1'b1;
                        beats_q   <= '0;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (more_beats) begin
                            wb_addr <= wb_addr + AW'(1);
                            beats_q <= beats_q - LW'(1);
                            wb_cyc  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WB_CMD_TIMEOUT_EN
    logic wdog_clr;

    assign wdog_clr = ((state_q == IDLE) && cmd_valid) ||
                      ((state_q == RSP) && rsp_ready && more_beats);

    wb_cmd_wdog #(
        .W(TO_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .en      (state_q == BUS),
        .expired (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (state_q == BUS) begin
            if (wb_ack) begin
                rsp_err <= 1'b0;
            end else if (expire) begin
                rsp_err <= 1'b1;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: a high-level model queues the expected
// bus beats and responses per command; negedge monitors pop and compare.
module tb_wb_cmd_master;
    import wb_cmd_master_pkg::*;

    localparam int AW = 8;
    localparam int LW = 4;
`ifdef WB_CMD_TIMEOUT_EN
    localparam int TO_W = 4;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_last;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_wdata;
    logic          wb_we;
    logic          wb_cyc;
    logic [31:0]   wb_rdata;
    logic          wb_ack;
    state_t        dbg_state;

    logic bp_random   = 1'b0;
    logic ready_force = 1'b1;
    logic rnd_ready   = 1'b1;
    logic no_ack      = 1'b0;
    logic stray_ack   = 1'b0;
    logic ack_q;

    assign rsp_ready = bp_random ? rnd_ready : ready_force;

    wb_cmd_master #(
        .AW(AW),
        .LW(LW)
`ifdef WB_CMD_TIMEOUT_EN
        ,
        .TO_W(TO_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_last  (rsp_last),
        .wb_addr   (wb_addr),
        .wb_wdata  (wb_wdata),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_rdata  (wb_rdata),
        .wb_ack    (wb_ack),
        .dbg_state (dbg_state)
    );

    // slave: acks one cycle after cyc, read data is 0x1000 + address
    always @(posedge clk or posedge rst) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= wb_cyc && !ack_q && !no_ack;
    end
    assign wb_ack   = ack_q | stray_ack;
    assign wb_rdata = ack_q ? (32'h1000 + {24'h0, wb_addr}) : 32'h0;

    always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    // scoreboard
    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    logic ack_prev = 1'b0;
    logic [33:0] exp_q[$];      // {rdata, err, last}
    logic [40:0] exp_bus_q[$];  // {we, addr, wdata}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [33:0] er;
        logic [40:0] eb;
        if (rst) begin
            ack_prev = 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=0x%0h required=none", {rsp_rdata, rsp_err, rsp_last});
                end else begin
                    er = exp_q.pop_front();
                    check("rsp_beat", {rsp_rdata, rsp_err, rsp_last}, er);
                end
            end
            if (ack_prev) check("cyc_after_ack", wb_cyc, 1'b0);
            if (wb_cyc && wb_ack) begin
                ack_cnt++;
                if (exp_bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_unexpected actual=0x%0h required=none", {wb_we, wb_addr, wb_wdata});
                end else begin
                    eb = exp_bus_q.pop_front();
                    check("bus_beat", {wb_we, wb_addr, wb_wdata}, eb);
                end
            end
            ack_prev = wb_cyc && wb_ack;
        end
    end

    // driver tasks
    task automatic send(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] len, input bit model);
        int n;
        if (model) begin
            for (int i = 0; i <= int'(len); i++) begin
                logic [7:0] a;
                a = addr + 8'(i);
                exp_bus_q.push_back({we, a, wd});
                exp_q.push_back({(we ? 32'h0 : (32'h1000 + {24'h0, a})), 1'b0, (i == int'(len))});
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_len   = len;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL cmd_handshake_timeout actual=%0d required=<300", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        checks++;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_bus_q.size() == 0 && cmd_ready) return;
        end
        failures++;
        $display("FAIL %s actual=pending(%0d,%0d) required=idle", name, exp_q.size(), exp_bus_q.size());
    endtask

    task automatic wait_rsp_valid(input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        checks++;
        failures++;
        $display("FAIL %s actual=no_rsp_valid required=rsp_valid", name);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int hi;
        int ack_base;

        repeat (3) @(posedge clk);
        #1;
        check("reset_bus", {wb_cyc, wb_we, wb_addr, wb_wdata}, 64'h0);
        check("reset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_last}, 64'h0);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // single write and its latency
        send(1'b1, 8'h02, 32'h000001A5, 4'd0, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) check("write_bus_cycle", {wb_cyc, wb_we, wb_addr, wb_wdata}, {1'b1, 1'b1, 8'h02, 32'h000001A5});
            if (rsp_valid) break;
        end
        check("write_rsp_latency", n, 3);
        wait_idle("write_idle", 50);

        // burst read, then address wrap
        send(1'b0, 8'h04, 32'h0, 4'd3, 1'b1);
        wait_idle("burst_idle", 100);
        send(1'b0, 8'hFE, 32'h0, 4'd3, 1'b1);
        wait_idle("wrap_idle", 100);

        // ack while idle is ignored
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_ack_ignored", {wb_cyc, rsp_valid, dbg_state}, {1'b0, 1'b0, IDLE});
        end
        @(posedge clk);
        #1;
        stray_ack = 1'b0;

        // backpressure on beat 2 of a 3-beat read
        ack_base    = ack_cnt;
        ready_force = 1'b0;
        send(1'b0, 8'h20, 32'h0, 4'd2, 1'b1);
        wait_rsp_valid("bp_beat1");
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        wait_rsp_valid("bp_beat2");
        repeat (10) begin
            @(negedge clk);
            check("bp_hold", {wb_cyc, rsp_valid, rsp_rdata, rsp_last}, {1'b0, 1'b1, 32'h1021, 1'b0});
        end
        check("bp_no_extra_bus", ack_cnt, ack_base + 2);
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        wait_idle("bp_idle", 100);
        check("bp_total_beats", ack_cnt, ack_base + 3);

        // silent slave
        no_ack = 1'b1;
`ifdef WB_CMD_TIMEOUT_EN
        exp_q.push_back({32'h0, 1'b1, 1'b1});
        send(1'b0, 8'h40, 32'h0, 4'd5, 1'b0);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!wb_cyc) break;
            hi++;
        end
        checks++;
        if (hi < 15 || hi > 16) begin
            failures++;
            $display("FAIL timeout_cyc_cycles actual=%0d required=15..16", hi);
        end
        wait_idle("timeout_idle", 100);
        send(1'b1, 8'h55, 32'hDEAD0001, 4'd2, 1'b0);
        repeat (4) @(negedge clk);
`else
        send(1'b0, 8'h40, 32'h0, 4'd5, 1'b0);
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_cyc) hi++;
        end
        check("hang_cyc_high", hi, 40);
`endif
        check("pre_reset_cyc", {wb_cyc, rsp_valid}, 2'b10);

        // asynchronous reset mid-beat
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_beat", {wb_cyc, rsp_valid, cmd_ready}, 3'b000);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        no_ack = 1'b0;
        send(1'b0, 8'h10, 32'h0, 4'd1, 1'b1);
        wait_idle("post_reset_idle", 100);

        // random commands with random backpressure
        bp_random = 1'b1;
        for (int k = 0; k < 25; k++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom,
                 4'($urandom_range(0, 15)), 1'b1);
        end
        wait_idle("random_idle", 3000);
        bp_random = 1'b0;

        check("exp_q_empty", exp_q.size(), 0);
        check("exp_bus_q_empty", exp_bus_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
